// File: rtl/sha_padder.sv
// rtl/sha_padder.sv - SHA-256 message padder: packs bytes into 512-bit blocks
// and appends the 0x80 marker, zero fill and 64-bit big-endian bit length.
module sha_padder (
   input  logic         clk,
   input  logic         clr,
   input  logic [7:0]   in_data,
   input  logic         in_valid,
   input  logic         in_last,
   output logic         in_ready,
   input  logic         core_done,
   output logic [511:0] blk_data,
   output logic         blk_valid,
   output logic         blk_first,
   output logic         blk_last,
   output logic         msg_done
);

   typedef enum logic [2:0] {
      S_FILL,
      S_PAD,
      S_LEN,
      S_EMIT,
      S_WAIT
   } state_t;

   state_t         r_state;
   state_t         w_next;
   logic [5:0]     r_idx;
   logic [60:0]    r_byte_cnt;
   logic           r_pad_pend;
   logic           r_need_len;
   logic           r_blk_last;
   logic           r_blk_first;
   logic           r_msg_done;
   logic [511:0]   r_blk;
   logic [511:0]   w_pad_blk;
   logic [63:0]    w_bitlen;
   logic           w_accept;
   logic           w_ack;

   assign w_accept  = (r_state == S_FILL) && in_valid;
   assign w_ack     = (r_state == S_WAIT) && core_done;
   assign w_bitlen  = {r_byte_cnt, 3'b000};

   assign in_ready  = (r_state == S_FILL);
   assign blk_valid = (r_state == S_EMIT);
   assign blk_data  = r_blk;
   assign blk_first = r_blk_first;
   assign blk_last  = r_blk_last;
   assign msg_done  = r_msg_done;

   // Bytes below idx hold message data; marker at idx, zeros above, length if it fits.
   always_comb begin
      w_pad_blk = r_blk;
      for (int k = 0; k < 64; k++) begin
         if (6'(k) == r_idx) begin
            w_pad_blk[8*(63-k) +: 8] = 8'h80;
         end else if (6'(k) > r_idx) begin
            w_pad_blk[8*(63-k) +: 8] = 8'h00;
         end
      end
      if (r_idx <= 6'd55) begin
         w_pad_blk[63:0] = w_bitlen;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FILL: begin
            if (in_valid) begin
               if (r_idx == 6'd63) begin
                  w_next = S_EMIT;
               end else if (in_last) begin
                  w_next = S_PAD;
               end
            end
         end
         S_PAD:  w_next = S_EMIT;
         S_LEN:  w_next = S_EMIT;
         S_EMIT: w_next = S_WAIT;
         S_WAIT: begin
            if (core_done) begin
               if (r_blk_last) begin
                  w_next = S_FILL;
               end else if (r_need_len) begin
                  w_next = S_LEN;
               end else if (r_pad_pend) begin
                  w_next = S_PAD;
               end else begin
                  w_next = S_FILL;
               end
            end
         end
         default: w_next = S_FILL;
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_state <= S_FILL;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_idx       <= 6'd0;
         r_byte_cnt  <= 61'd0;
         r_pad_pend  <= 1'b0;
         r_need_len  <= 1'b0;
         r_blk_last  <= 1'b0;
         r_blk_first <= 1'b1;
         r_msg_done  <= 1'b0;
         r_blk       <= 512'd0;
      end else begin
         r_msg_done <= 1'b0;
         if (w_accept) begin
            r_blk[{~r_idx, 3'b000} +: 8] <= in_data;
            r_idx      <= r_idx + 6'd1;
            r_byte_cnt <= r_byte_cnt + 61'd1;
            if (r_idx == 6'd63) begin
               r_pad_pend <= in_last;
            end
         end
         if (r_state == S_PAD) begin
            r_blk <= w_pad_blk;
            if (r_idx <= 6'd55) begin
               r_blk_last <= 1'b1;
            end else begin
               r_need_len <= 1'b1;
            end
         end
         if (r_state == S_LEN) begin
            r_blk      <= {448'd0, w_bitlen};
            r_blk_last <= 1'b1;
         end
         // Index wraps to zero after a full block, so the next block starts at byte 0.
         if (w_ack) begin
            r_idx      <= 6'd0;
            r_pad_pend <= 1'b0;
            r_need_len <= 1'b0;
            if (r_blk_last) begin
               r_byte_cnt  <= 61'd0;
               r_blk_last  <= 1'b0;
               r_blk_first <= 1'b1;
               r_msg_done  <= 1'b1;
            end else begin
               r_blk_first <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_sha_padder.sv
// tb/tb_sha_padder.sv - randomized self-checking bench for sha_padder against
// a queue-based SHA-256 padding reference model.
module tb_sha_padder;

   logic         clk = 1'b0;
   logic         clr;
   logic [7:0]   in_data;
   logic         in_valid;
   logic         in_last;
   logic         in_ready;
   logic         core_done;
   logic [511:0] blk_data;
   logic         blk_valid;
   logic         blk_first;
   logic         blk_last;
   logic         msg_done;

   int           n_checks = 0;
   int           n_fail = 0;
   int           ncyc = 0;
   bit           timed_out;
   logic [7:0]   msg [0:255];
   int           acc [0:255];
   logic [511:0] exp_q [$];
   logic [511:0] got_q [$];

   localparam logic [511:0] ABC_BLK = {24'h616263, 8'h80, 416'd0, 64'h18};

   sha_padder dut (
      .clk       (clk),
      .clr       (clr),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .core_done (core_done),
      .blk_data  (blk_data),
      .blk_valid (blk_valid),
      .blk_first (blk_first),
      .blk_last  (blk_last),
      .msg_done  (msg_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) ncyc <= ncyc + 1;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Standard SHA-256 padding: message, 0x80, zeros to 56 mod 64, 64-bit bit length.
   task automatic build_expected(input int len);
      logic [7:0]   pad [$];
      logic [63:0]  bitlen;
      logic [511:0] blk;
      exp_q.delete();
      for (int i = 0; i < len; i++) pad.push_back(msg[i]);
      pad.push_back(8'h80);
      while (pad.size() % 64 != 56) pad.push_back(8'h00);
      bitlen = 64'(len) * 64'd8;
      for (int k = 7; k >= 0; k--) pad.push_back(bitlen[8*k +: 8]);
      for (int b = 0; b < pad.size() / 64; b++) begin
         blk = '0;
         for (int k = 0; k < 64; k++) blk[8*(63-k) +: 8] = pad[64*b + k];
         exp_q.push_back(blk);
      end
   endtask

   task automatic feed(input int n, input bit with_last);
      int t;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 2)) @(negedge clk);
         end
         in_valid = 1'b1;
         in_data  = msg[i];
         in_last  = with_last && (i == n - 1);
         t = 0;
         while (!in_ready && t < 600) begin
            @(negedge clk);
            t++;
         end
         if (!in_ready) begin
            check("feed_timeout", 512'(0), 512'(1));
            timed_out = 1'b1;
            in_valid  = 1'b0;
            return;
         end
         @(posedge clk);
         acc[i] = ncyc;
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic monitor(input int len);
      int           t;
      int           nblk;
      logic [511:0] held;
      nblk = exp_q.size();
      for (int b = 0; b < nblk; b++) begin
         t = 0;
         @(negedge clk);
         while (!blk_valid && t < 600) begin
            @(negedge clk);
            t++;
         end
         if (!blk_valid) begin
            check("blk_timeout", 512'(0), 512'(1));
            timed_out = 1'b1;
            return;
         end
         got_q.push_back(blk_data);
         check("blk_data", blk_data, exp_q[b]);
         check("blk_first", 512'(blk_first), 512'(b == 0));
         check("blk_last", 512'(blk_last), 512'(b == nblk - 1));
         if (64*b + 63 < len) begin
            check("lat_full", 512'(ncyc), 512'(acc[64*b + 63] + 1));
         end else if ((len - 1) / 64 == b) begin
            check("lat_last", 512'(ncyc), 512'(acc[len - 1] + 2));
         end
         held = blk_data;
         core_done = 1'($urandom_range(0, 1));
         @(negedge clk);
         core_done = 1'b0;
         check("blk_valid_pulse", 512'(blk_valid), 512'(0));
         repeat ($urandom_range(0, 3)) @(negedge clk);
         check("wait_ready", 512'(in_ready), 512'(0));
         check("blk_hold", blk_data, held);
         core_done = 1'b1;
         @(negedge clk);
         core_done = 1'b0;
         check("msg_done", 512'(msg_done), 512'(b == nblk - 1));
      end
      check("ready_after", 512'(in_ready), 512'(1));
   endtask

   task automatic run_msg(input int len);
      timed_out = 1'b0;
      got_q.delete();
      build_expected(len);
      fork
         feed(len, 1'b1);
         monitor(len);
      join
   endtask

   task automatic fill_msg(input int len, input bit rnd, input logic [7:0] val);
      for (int i = 0; i < len; i++) msg[i] = rnd ? 8'($urandom) : val;
   endtask

   task automatic set_abc();
      msg[0] = 8'h61;
      msg[1] = 8'h62;
      msg[2] = 8'h63;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_ready"}, 512'(in_ready), 512'(1));
      check({tag, "_valid"}, 512'(blk_valid), 512'(0));
      check({tag, "_data"}, blk_data, 512'd0);
      check({tag, "_first"}, 512'(blk_first), 512'(1));
      check({tag, "_last"}, 512'(blk_last), 512'(0));
      check({tag, "_done"}, 512'(msg_done), 512'(0));
   endtask

   task automatic pulse_reset(input string tag);
      #2 clr = 1'b0;
      #1 check_reset_state(tag);
      in_valid  = 1'b0;
      in_last   = 1'b0;
      core_done = 1'b0;
      @(negedge clk);
      clr = 1'b1;
   endtask

   task automatic run_abc(input string tag);
      set_abc();
      run_msg(3);
      check({tag, "_cnt"}, 512'(got_q.size()), 512'(1));
      if (got_q.size() > 0) check({tag, "_blk"}, got_q[0], ABC_BLK);
   endtask

   initial begin
      int lens [7] = '{1, 63, 119, 120, 127, 128, 129};
      clr       = 1'b0;
      in_data   = 8'h00;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      core_done = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_state("rst");
      clr = 1'b1;

      run_abc("abc");

      fill_msg(55, 1'b0, 8'h00);
      run_msg(55);
      if (got_q.size() > 0) check("z55_blk", got_q[0], {440'd0, 8'h80, 64'h1B8});

      fill_msg(56, 1'b0, 8'hFF);
      run_msg(56);
      check("f56_cnt", 512'(got_q.size()), 512'(2));
      if (got_q.size() > 1) check("f56_len", got_q[1], {448'd0, 64'h1C0});

      fill_msg(64, 1'b0, 8'h11);
      run_msg(64);
      check("e64_cnt", 512'(got_q.size()), 512'(2));
      if (got_q.size() > 1) check("e64_pad", got_q[1], {8'h80, 440'd0, 64'h200});

      for (int i = 0; i < 7; i++) begin
         fill_msg(lens[i], 1'b1, 8'h00);
         run_msg(lens[i]);
         if (timed_out) pulse_reset("recover");
      end
      for (int i = 0; i < 25; i++) begin
         int len;
         len = $urandom_range(1, 200);
         fill_msg(len, 1'b1, 8'h00);
         run_msg(len);
         if (timed_out) pulse_reset("recover");
      end

      fill_msg(20, 1'b1, 8'h00);
      feed(20, 1'b0);
      pulse_reset("rst_mid");
      run_abc("abc_mid");

      fill_msg(64, 1'b1, 8'h00);
      feed(64, 1'b0);
      @(negedge clk);
      check("in_wait", 512'(in_ready), 512'(0));
      pulse_reset("rst_wait");
      run_abc("abc_wait");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
